mc_datapath_gen: RTL

//   Parametrised multicycle datapath with its own phase sequencer for the RISC processor family.

---
 rtl/mc_datapath_gen.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/mc_datapath_gen.sv
// Parametrised multicycle RISC datapath with its own phase sequencer.
// Talks to a unified instruction/data memory over a req/ack port that tolerates wait states.
module mc_datapath_gen #(
  parameter int DW   = 16,
  parameter int AW   = 8,
  parameter int NREG = 8
) (
  input  logic          clk,
  input  logic          Rst,
  input  logic          start,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [AW-1:0] pc_o,
  output logic [DW-1:0] ins_o,
  output logic [2:0]    psw_o,
  output logic [2:0]    state_o,
  output logic          halted
);

  localparam int RW = $clog2(NREG);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_LI   = 4'h4;
  localparam logic [3:0] OP_LD   = 4'h5;
  localparam logic [3:0] OP_ST   = 4'h6;
  localparam logic [3:0] OP_BZ   = 4'h7;
  localparam logic [3:0] OP_JR   = 4'h8;
  localparam logic [3:0] OP_JAL  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [AW-1:0]   pc;
  logic [DW-1:0]   ir;
  logic [DW-1:0]   a_q;
  logic [DW-1:0]   b_q;
  logic [DW-1:0]   alu_q;
  logic            flag_n;
  logic            flag_z;
  logic            flag_c;
  logic [DW-1:0]   regs [NREG];

  logic [3:0]      op;
  logic [RW-1:0]   rd;
  logic [RW-1:0]   rm;
  logic [7:0]      imm;
  logic            is_alu;
  logic            writes_rd;
  logic [DW:0]     sum;
  logic [DW-1:0]   alu_res;
  logic            alu_c;

  assign op        = ir[DW-1 -: 4];
  assign rd        = ir[DW-5 -: RW];
  assign rm        = ir[DW-5-RW -: RW];
  assign imm       = ir[7:0];
  assign is_alu    = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  assign writes_rd = is_alu || (op == OP_LI) || (op == OP_LD) || (op == OP_JAL);

  // SUB is done as A + ~B + 1 so the carry out is the "no borrow" flag.
  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    case (op)
      OP_ADD: begin
        sum     = {1'b0, a_q} + {1'b0, b_q};
        alu_res = sum[DW-1:0];
        alu_c   = sum[DW];
      end
      OP_SUB: begin
        sum     = {1'b0, a_q} + {1'b0, ~b_q} + {{DW{1'b0}}, 1'b1};
        alu_res = sum[DW-1:0];
        alu_c   = sum[DW];
      end
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_LI:   alu_res = DW'(imm);
      OP_JAL:  alu_res = DW'(pc);
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Memory outputs are decoded from registered state only, so they hold steady through wait states.
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = pc;
    mem_wdata  = a_q;
    case (state)
      S_IDLE, S_HALT: begin
        if (start) state_next = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) state_next = S_DECODE;
      end
      S_DECODE: begin
        state_next = (op == OP_HALT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        case (op)
          OP_LD, OP_ST: state_next = S_MEM;
          OP_BZ, OP_JR: state_next = S_FETCH;
          default:      state_next = S_WB;
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_we   = (op == OP_ST);
        mem_addr = AW'(b_q);
        if (mem_ack) state_next = (op == OP_LD) ? S_WB : S_FETCH;
      end
      S_WB: begin
        state_next = S_FETCH;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // The PC already points past the current instruction by EXEC, which gives branch offsets and JAL links their base.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      pc     <= '0;
      ir     <= '0;
      a_q    <= '0;
      b_q    <= '0;
      alu_q  <= '0;
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) pc <= '0;
        end
        S_FETCH: begin
          if (mem_ack) begin
            ir <= mem_rdata;
            pc <= pc + AW'(1);
          end
        end
        S_DECODE: begin
          a_q <= regs[rd];
          b_q <= regs[rm];
        end
        S_EXEC: begin
          alu_q <= alu_res;
          if (is_alu) begin
            flag_n <= alu_res[DW-1];
            flag_z <= (alu_res == '0);
            flag_c <= alu_c;
          end
          if (op == OP_BZ && flag_z) pc <= pc + AW'($signed(imm));
          if (op == OP_JR || op == OP_JAL) pc <= AW'(b_q);
        end
        S_MEM: begin
          if (mem_ack && op == OP_LD) alu_q <= mem_rdata;
        end
        S_WB: begin
          if (writes_rd) regs[rd] <= alu_q;
        end
        default: ;
      endcase
    end
  end

  assign pc_o    = pc;
  assign ins_o   = ir;
  assign psw_o   = {flag_n, flag_z, flag_c};
  assign state_o = state;
  assign halted  = (state == S_HALT);

endmodule
